// File: rtl/cpu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_wb_arbiter
//
// Merges the ALU writeback stream and the fixed-latency multiplier writeback
// stream onto the single register-file write port. The multiplier pipe cannot
// stall, so a multiplier result that loses arbitration is parked in a small
// in-order FIFO. The ALU is back-pressured so the FIFO never overflows. An
// accepted ALU write kills older parked multiplier writes to the same register,
// which keeps write-after-write order intact.
//
// Priority each cycle: accepted ALU > FIFO head > multiplier bypass > idle.
//
// Optional build macro: CPU_WB_STALL_CNT_EN adds the saturating stall_cycles
// counter (ALU cycles spent valid but not ready).
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-low reset (0 = reset)
//   alu_wb_*      ALU writeback: valid/rd/data in, ready out
//   mul_wb_*      multiplier writeback: valid/rd/data in (never stalled)
//   rf_we/rd/data registered register-file write port
//   fifo_count    registered park-FIFO occupancy (debug)
//   stall_cycles  saturating ALU stall counter (CPU_WB_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module cpu_wb_arbiter #(
  parameter  int DATA_W     = 32,
  parameter  int RD_W       = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_wb_valid,
  input  logic [RD_W-1:0]   alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mul_wb_valid,
  input  logic [RD_W-1:0]   mul_wb_rd,
  input  logic [DATA_W-1:0] mul_wb_data,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic [CNT_W-1:0]  fifo_count
`ifdef CPU_WB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO,
    SEL_MUL
  } sel_e;

  // Park FIFO: payload arrays plus a per-slot live bit that squash can clear.
  logic [RD_W-1:0]       q_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_live;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  sel_e sel;
  logic alu_acc;
  logic fifo_empty;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends on registered occupancy only, so there is no combinational
  // path from either writeback input to alu_wb_ready.
  assign alu_wb_ready = (fifo_count < CNT_W'(FIFO_DEPTH - 1));
  assign alu_acc      = alu_wb_valid && alu_wb_ready;
  assign fifo_empty   = (fifo_count == '0);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sel  = SEL_NONE;
    push = 1'b0;
    pop  = 1'b0;
    if (alu_acc) begin
      sel  = SEL_ALU;
      // The ALU op is younger: a same-cycle multiplier write to the same rd
      // would be overwritten anyway, so it is never parked.
      push = mul_wb_valid && (mul_wb_rd != alu_wb_rd);
    end else if (!fifo_empty) begin
      sel  = SEL_FIFO;
      pop  = 1'b1;
      push = mul_wb_valid;
    end else if (mul_wb_valid) begin
      sel  = SEL_MUL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_data    <= '0;
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      q_live     <= '0;
    end else begin
      rf_we <= 1'b0;
      unique case (sel)
        SEL_ALU: begin
          rf_we   <= 1'b1;
          rf_rd   <= alu_wb_rd;
          rf_data <= alu_wb_data;
        end
        SEL_FIFO: begin
          // A killed head still consumes its slot but writes nothing.
          rf_we <= q_live[head];
          if (q_live[head]) begin
            rf_rd   <= q_rd[head];
            rf_data <= q_data[head];
          end
        end
        SEL_MUL: begin
          rf_we   <= 1'b1;
          rf_rd   <= mul_wb_rd;
          rf_data <= mul_wb_data;
        end
        default: rf_we <= 1'b0;
      endcase

      if (alu_acc) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (q_live[i] && (q_rd[i] == alu_wb_rd)) q_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= ptr_inc(head);
      end
      // Push lands on the tail slot, which is never the popped head while the
      // FIFO is non-empty and below full.
      if (push) begin
        q_live[tail] <= 1'b1;
        tail         <= ptr_inc(tail);
      end

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: payload storage is not reset; the live bits alone say which slots hold data.
  always_ff @(posedge clock) begin
    if (push) begin
      q_rd[tail]   <= mul_wb_rd;
      q_data[tail] <= mul_wb_data;
    end
  end

`ifdef CPU_WB_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (alu_wb_valid && !alu_wb_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_wb_arbiter
//
// Self-checking bench for cpu_wb_arbiter (DATA_W=32, RD_W=4, FIFO_DEPTH=4).
// A table of per-cycle vectors covers reset, bypass, collision, squash and
// FIFO-before-bypass ordering; a hand-written backpressure sequence uses
// per-stream expected-write queues to check in-order retirement.
// -----------------------------------------------------------------------------
module tb_cpu_wb_arbiter;

  localparam int DATA_W     = 32;
  localparam int RD_W       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              alu_wb_valid;
  logic [RD_W-1:0]   alu_wb_rd;
  logic [DATA_W-1:0] alu_wb_data;
  logic              alu_wb_ready;
  logic              mul_wb_valid;
  logic [RD_W-1:0]   mul_wb_rd;
  logic [DATA_W-1:0] mul_wb_data;
  logic              rf_we;
  logic [RD_W-1:0]   rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic [CNT_W-1:0]  fifo_count;
`ifdef CPU_WB_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  cpu_wb_arbiter #(
    .DATA_W    (DATA_W),
    .RD_W      (RD_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_wb_valid(alu_wb_valid),
    .alu_wb_rd   (alu_wb_rd),
    .alu_wb_data (alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mul_wb_valid(mul_wb_valid),
    .mul_wb_rd   (mul_wb_rd),
    .mul_wb_data (mul_wb_data),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .fifo_count  (fifo_count)
`ifdef CPU_WB_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string             name;
    logic              rst_n;
    logic              alu_v;
    logic [RD_W-1:0]   alu_rd;
    logic [DATA_W-1:0] alu_d;
    logic              mul_v;
    logic [RD_W-1:0]   mul_rd;
    logic [DATA_W-1:0] mul_d;
    logic              e_we;
    logic              chk_rd;
    logic [RD_W-1:0]   e_rd;
    logic [DATA_W-1:0] e_data;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_rdy;
  } vec_t;

  typedef struct {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] d;
  } wb_t;

  vec_t vecs[$];
  wb_t  alu_q[$];
  wb_t  mul_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst_n,
                              input logic av, input int ard, input int ad,
                              input logic mv, input int mrd, input int md,
                              input logic ewe, input logic chk, input int erd, input int ed,
                              input int ecnt, input logic erdy);
    vec_t v;
    v.name = name;    v.rst_n = rst_n;
    v.alu_v = av;     v.alu_rd = RD_W'(ard);   v.alu_d = DATA_W'(ad);
    v.mul_v = mv;     v.mul_rd = RD_W'(mrd);   v.mul_d = DATA_W'(md);
    v.e_we = ewe;     v.chk_rd = chk;          v.e_rd = RD_W'(erd);
    v.e_data = DATA_W'(ed); v.e_cnt = CNT_W'(ecnt); v.e_rdy = erdy;
    return v;
  endfunction

  task automatic drive(input logic rst_n, input logic av, input logic [RD_W-1:0] ard,
                       input logic [DATA_W-1:0] ad, input logic mv,
                       input logic [RD_W-1:0] mrd, input logic [DATA_W-1:0] md);
    reset        = rst_n;
    alu_wb_valid = av;
    alu_wb_rd    = ard;
    alu_wb_data  = ad;
    mul_wb_valid = mv;
    mul_wb_rd    = mrd;
    mul_wb_data  = md;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  alu_issued = 0;
    int  mul_issued = 0;
    int  stalls     = 0;
    int  max_cnt    = 0;
    bit  done       = 0;
    wb_t e;

    //            name          rst av ard  ad    mv mrd md    we chk rd  data  cnt rdy
    vecs.push_back(mk("reset",      0, 0, 0, 0,    0, 0, 0,    0, 1, 0, 0,    0, 1));
    vecs.push_back(mk("mul_bypass", 1, 0, 0, 0,    1, 5, 'h30, 1, 1, 5, 'h30, 0, 1));
    vecs.push_back(mk("idle_hold",  1, 0, 0, 0,    0, 0, 0,    0, 1, 5, 'h30, 0, 1));
    vecs.push_back(mk("collide",    1, 1, 2, 'h11, 1, 3, 'h22, 1, 1, 2, 'h11, 1, 1));
    vecs.push_back(mk("collide_pop",1, 0, 0, 0,    0, 0, 0,    1, 1, 3, 'h22, 0, 1));
    vecs.push_back(mk("park_rd7",   1, 1, 1, 'h01, 1, 7, 'h77, 1, 1, 1, 'h01, 1, 1));
    vecs.push_back(mk("alu_rd7",    1, 1, 7, 'hAA, 0, 0, 0,    1, 1, 7, 'hAA, 1, 1));
    vecs.push_back(mk("pop_killed", 1, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0,    0, 1));
    vecs.push_back(mk("same_squash",1, 1, 4, 'h44, 1, 4, 'h99, 1, 1, 4, 'h44, 0, 1));
    vecs.push_back(mk("squash_idle",1, 0, 0, 0,    0, 0, 0,    0, 1, 4, 'h44, 0, 1));
    vecs.push_back(mk("fill1",      1, 1, 1, 'hA1, 1, 8, 'h81, 1, 1, 1, 'hA1, 1, 1));
    vecs.push_back(mk("fill2",      1, 1, 2, 'hA2, 1, 9, 'h82, 1, 1, 2, 'hA2, 2, 1));
    vecs.push_back(mk("reset_full", 0, 0, 0, 0,    0, 0, 0,    0, 1, 0, 0,    0, 1));
    vecs.push_back(mk("post_reset", 1, 0, 0, 0,    0, 0, 0,    0, 1, 0, 0,    0, 1));
    vecs.push_back(mk("order_a",    1, 1, 1, 'h10, 1, 2, 'h20, 1, 1, 1, 'h10, 1, 1));
    vecs.push_back(mk("fifo_first", 1, 0, 0, 0,    1, 3, 'h30, 1, 1, 2, 'h20, 1, 1));
    vecs.push_back(mk("order_c",    1, 0, 0, 0,    0, 0, 0,    1, 1, 3, 'h30, 0, 1));

    drive(0, 0, '0, '0, 0, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d,
            vecs[i].mul_v, vecs[i].mul_rd, vecs[i].mul_d);
      @(posedge clock);
      @(negedge clock);
      check({vecs[i].name, ".we"},    32'(rf_we),        32'(vecs[i].e_we));
      check({vecs[i].name, ".count"}, 32'(fifo_count),   32'(vecs[i].e_cnt));
      check({vecs[i].name, ".ready"}, 32'(alu_wb_ready), 32'(vecs[i].e_rdy));
      if (vecs[i].chk_rd) begin
        check({vecs[i].name, ".rd"},   32'(rf_rd), 32'(vecs[i].e_rd));
        check({vecs[i].name, ".data"}, rf_data,    vecs[i].e_data);
      end
    end

    // Backpressure: ALU valid every cycle for six ops (rd 10..15) while the
    // multiplier issues six results back to back (rd 1..6). ALU holds its
    // request stable while not ready.
    reset = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      alu_wb_valid = (alu_issued < 6);
      alu_wb_rd    = RD_W'(10 + alu_issued);
      alu_wb_data  = DATA_W'(32'hA00 + alu_issued);
      mul_wb_valid = (mul_issued < 6);
      mul_wb_rd    = RD_W'(1 + mul_issued);
      mul_wb_data  = DATA_W'(32'h100 + mul_issued);
      if (mul_wb_valid) begin
        e.rd = mul_wb_rd; e.d = mul_wb_data;
        mul_q.push_back(e);
        mul_issued++;
      end
      if (alu_wb_valid) begin
        if (alu_wb_ready) begin
          e.rd = alu_wb_rd; e.d = alu_wb_data;
          alu_q.push_back(e);
          alu_issued++;
        end else begin
          stalls++;
        end
      end
      @(posedge clock);
      @(negedge clock);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (rf_we) begin
        if (rf_rd >= RD_W'(10)) begin
          if (alu_q.size() == 0) check("bp.unexpected_alu_write", 32'(rf_we), 32'd0);
          else begin
            e = alu_q.pop_front();
            check("bp.alu_rd",   32'(rf_rd), 32'(e.rd));
            check("bp.alu_data", rf_data,    e.d);
          end
        end else begin
          if (mul_q.size() == 0) check("bp.unexpected_mul_write", 32'(rf_we), 32'd0);
          else begin
            e = mul_q.pop_front();
            check("bp.mul_rd",   32'(rf_rd), 32'(e.rd));
            check("bp.mul_data", rf_data,    e.d);
          end
        end
      end
      alu_wb_valid = 1'b0;
      mul_wb_valid = 1'b0;
      done = (alu_issued == 6) && (mul_issued == 6) &&
             (alu_q.size() == 0) && (mul_q.size() == 0);
    end
    check("bp.all_retired",  32'(done),         32'd1);
    check("bp.max_count",    32'(max_cnt),      32'd3);
    check("bp.stall_cycles", 32'(stalls),       32'd4);
    check("bp.final_count",  32'(fifo_count),   32'd0);
    check("bp.final_ready",  32'(alu_wb_ready), 32'd1);
`ifdef CPU_WB_STALL_CNT_EN
    check("bp.stall_counter", stall_cycles, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_wb_arbiter.md
Name: cpu_wb_arbiter

Overview:
- Merges the ALU writeback stream and the fixed-latency multiplier writeback stream onto the single register-file write port.
- The multiplier pipe cannot stall, so any multiplier result that loses arbitration is parked in a small in-order FIFO.
- The ALU side is back-pressured with a ready signal so the FIFO can never overflow.
- Younger ALU writes squash older parked multiplier writes to the same register, preserving write-after-write (WAW) order.

Parameters:
- DATA_W, 32, register data width.
- RD_W, 4, register-id width (clog2 of the register count).
- FIFO_DEPTH, 4, multiplier park-FIFO entries; must be at least 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset.
- alu_wb_valid  input  1  ALU result present.
- alu_wb_rd  input  RD_W  ALU destination register.
- alu_wb_data  input  DATA_W  ALU result.
- alu_wb_ready  output  1  ALU result accepted this cycle when valid && ready.
- mul_wb_valid  input  1  multiplier result present (last pipe stage); never stalled.
- mul_wb_rd  input  RD_W  multiplier destination register.
- mul_wb_data  input  DATA_W  multiplier result.
- rf_we  output  1  register-file write enable (registered).
- rf_rd  output  RD_W  register-file write address (registered).
- rf_data  output  DATA_W  register-file write data (registered).
- fifo_count  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy (registered, debug).

Behaviour:
- Reset (reset==0 at a clock edge):
  - rf_we=0, rf_rd=0, rf_data=0.
  - FIFO emptied, all entry-valid bits cleared, fifo_count=0.
  - Any in-progress contents are discarded.
- alu_wb_ready = (fifo_count < FIFO_DEPTH-1). It is a combinational function of registered count only, with no dependence on the inputs in the same cycle.
- Each cycle, exactly one source is selected, in priority order:
  1. alu_wb_valid && alu_wb_ready: write the ALU result. A valid multiplier input is pushed to the FIFO unless squashed (see below).
  2. FIFO non-empty: pop the head. If the head entry is live, write it; if killed, rf_we=0 (slot consumed, no write). A valid multiplier input is pushed.
  3. mul_wb_valid: write the multiplier result directly (bypass, no FIFO).
  4. Otherwise rf_we=0; rf_rd and rf_data hold their previous values.
- Latency: the selected source appears on rf_* one cycle after selection. The bypass path therefore has 1-cycle latency.
- Squash (WAW) rules:
  - On an accepted ALU write with rd=R, every live FIFO entry with rd==R is killed in the same edge.
  - A multiplier input arriving that cycle with rd==R is dropped, not pushed. The ALU instruction is the younger one.
- Ordering: FIFO entries drain in arrival order. No FIFO entry is written ahead of an older one, and no multiplier input bypasses a non-empty FIFO.
- Push and pop in the same cycle: occupancy is unchanged and pointers advance modulo FIFO_DEPTH (wrap-around).
- Occupancy never exceeds FIFO_DEPTH-1:
  - Pushes beyond FIFO_DEPTH-2 happen only while alu_wb_ready=1.
  - At FIFO_DEPTH-1, ready=0, so every push is paired with a pop.
  - A push when count==FIFO_DEPTH is a design error and is flagged by a simulation assertion.
- Empty FIFO with alu_wb_ready=0 is unreachable.
- Upstream contract: while alu_wb_valid=1 and alu_wb_ready=0, upstream holds alu_wb_rd and alu_wb_data stable.
- Data widths pass through unmodified; no register-0 filtering is performed (the register file owns that).

Optional Feature:
- Macro: CPU_WB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0], reset to 0.
  - Increments on every cycle with alu_wb_valid=1 and alu_wb_ready=0.
  - Saturates at 32'hFFFF_FFFF.
- Undefined:
  - Port and counter are absent.
  - Arbitration behaviour is identical.

Test Plan:
- Reset with FIFO holding 2 entries -> next cycle rf_we=0, fifo_count=0, alu_wb_ready=1.
- Multiplier only (rd=5, data=0x0000_0030), no ALU -> rf_we=1, rf_rd=5, rf_data=0x30 one cycle later; fifo_count stays 0.
- Collision: ALU (rd=2, 0x11) and multiplier (rd=3, 0x22) in the same cycle, then idle -> write rd2=0x11, then rd3=0x22 the next cycle; fifo_count goes 1 then 0.
- Backpressure: FIFO_DEPTH=4; ALU valid every cycle while multiplier valid for 6 cycles -> fifo_count reaches 3, alu_wb_ready drops to 0, count never exceeds 3, all 6 multiplier writes retire in order.
- WAW squash: multiplier rd=7 parked, then ALU rd=7 data 0xAA accepted -> rd7=0xAA written; popping the killed entry gives rf_we=0; final rd7 write value is 0xAA.
- Same-cycle squash: ALU rd=4 and multiplier rd=4 together -> only the ALU write occurs and fifo_count is unchanged. With CPU_WB_STALL_CNT_EN defined, stall_cycles counts the backpressure cycles exactly.
